// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit: access-size encodings,
// the FSM state type and the datapath word width.
package lsu_pkg;

  localparam int WORD_W = 32;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_if.sv
// Core-side request/response bundle of the load/store unit.
// The master modport is the core's memory stage; the slave modport is the LSU.
interface lsu_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/lsu_byte_lane.sv
// Combinational byte-lane logic: extracts and extends load data from a memory
// word, and merges right-aligned store data into the old word for sub-word stores.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [WORD_W-1:0] old_word,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  input  logic [1:0]        lane,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] load_data,
  output logic [WORD_W-1:0] merge_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection and sign/zero extension for loads.
  always_comb begin
    byte_s    = old_word[{lane, 3'b000} +: 8];
    half_s    = old_word[{lane[1], 4'b0000} +: 16];
    load_data = old_word;
    case (size)
      SIZE_B: begin
        if (is_unsigned) begin
          load_data = {24'h000000, byte_s};
        end else begin
          load_data = {{24{byte_s[7]}}, byte_s};
        end
      end
      SIZE_H: begin
        if (is_unsigned) begin
          load_data = {16'h0000, half_s};
        end else begin
          load_data = {{16{half_s[15]}}, half_s};
        end
      end
      default: load_data = old_word;
    endcase
  end

  // Read-modify-write merge: only the addressed lane(s) take the new data.
  always_comb begin
    merge_data = old_word;
    case (size)
      SIZE_B:  merge_data[{lane, 3'b000} +: 8]     = wdata[7:0];
      SIZE_H:  merge_data[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      SIZE_W:  merge_data = wdata;
      default: merge_data = old_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Word-oriented load/store initiator for a single-port memory without byte
// enables. Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses;
// otherwise the low address bits are forced to alignment.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_DEPTH  = 100
) (
  input  logic                  CLK,
  input  logic                  RST,
  lsu_if.slave                  bus,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wd,
  input  logic [DATA_WIDTH-1:0] mem_rd
);

  lsu_state_e            state_r;
  lsu_state_e            state_nxt_s;

  logic                  we_r;
  logic [1:0]            size_r;
  logic                  uns_r;
  logic [1:0]            lane_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic [DATA_WIDTH-1:0] mem_addr_r;
  logic [DATA_WIDTH-1:0] mem_wd_r;
  logic [DATA_WIDTH-1:0] resp_rdata_r;
  logic                  resp_err_r;

  logic [ADDR_WIDTH-1:0] addr_s;
  logic [DATA_WIDTH-1:0] idx_s;
  logic [1:0]            lane_s;
  logic                  misalign_s;
  logic                  range_err_s;
  logic                  size_err_s;
  logic                  err_s;
  logic                  accept_s;
  logic [DATA_WIDTH-1:0] load_data_s;
  logic [DATA_WIDTH-1:0] merge_data_s;

  assign addr_s      = bus.req_addr;
  assign idx_s       = DATA_WIDTH'(addr_s >> 2);
  assign range_err_s = (idx_s >= DATA_WIDTH'(MEM_DEPTH));
  assign size_err_s  = (bus.req_size == 2'd3);
  assign err_s       = range_err_s | size_err_s | misalign_s;
  assign accept_s    = (state_r == IDLE) && bus.req_valid;

  // Alignment handling of the incoming request: trap or force alignment.
  always_comb begin
    lane_s     = addr_s[1:0];
    misalign_s = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    case (bus.req_size)
      SIZE_H:  misalign_s = addr_s[0];
      SIZE_W:  misalign_s = |addr_s[1:0];
      default: misalign_s = 1'b0;
    endcase
`else
    case (bus.req_size)
      SIZE_H:  lane_s = {addr_s[1], 1'b0};
      SIZE_W:  lane_s = 2'b00;
      default: lane_s = addr_s[1:0];
    endcase
`endif
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.req_valid) begin
          if (err_s) begin
            state_nxt_s = RESP;
          end else if (bus.req_we && (bus.req_size == SIZE_W)) begin
            state_nxt_s = WR;
          end else begin
            state_nxt_s = RD;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RD: begin
        if (we_r) begin
          state_nxt_s = WR;
        end else begin
          state_nxt_s = RESP;
        end
      end
      WR:      state_nxt_s = RESP;
      RESP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register; async reset also drops mem_we immediately.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Request latch, write-data/response registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      we_r         <= 1'b0;
      size_r       <= 2'd0;
      uns_r        <= 1'b0;
      lane_r       <= 2'd0;
      wdata_r      <= '0;
      mem_addr_r   <= '0;
      mem_wd_r     <= '0;
      resp_rdata_r <= '0;
      resp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            we_r       <= bus.req_we;
            size_r     <= bus.req_size;
            uns_r      <= bus.req_unsigned;
            lane_r     <= lane_s;
            wdata_r    <= bus.req_wdata;
            mem_addr_r <= idx_s;
            resp_err_r <= err_s;
            if (bus.req_we && (bus.req_size == SIZE_W)) begin
              mem_wd_r <= bus.req_wdata;
            end
          end
        end
        RD: begin
          // The old word is consumed here: merged for stores, extracted for loads.
          if (we_r) begin
            mem_wd_r     <= merge_data_s;
            resp_rdata_r <= '0;
          end else begin
            resp_rdata_r <= load_data_s;
          end
        end
        RESP: begin
          resp_rdata_r <= '0;
          resp_err_r   <= 1'b0;
        end
        default: begin
          resp_err_r <= resp_err_r;
        end
      endcase
    end
  end

  lsu_byte_lane u_byte_lane (
    .old_word    (mem_rd),
    .size        (size_r),
    .is_unsigned (uns_r),
    .lane        (lane_r),
    .wdata       (wdata_r),
    .load_data   (load_data_s),
    .merge_data  (merge_data_s)
  );

  assign mem_we         = (state_r == WR);
  assign mem_addr       = mem_addr_r;
  assign mem_wd         = mem_wd_r;
  assign bus.req_ready  = (state_r == IDLE);
  assign bus.resp_valid = (state_r == RESP);
  assign bus.resp_rdata = resp_rdata_r;
  assign bus.resp_err   = resp_err_r;

endmodule
